// File: rtl/ctrl_microondas_seq.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_microondas_seq
// Description : Multi-stage cooking program sequencer. Holds a table of
//               stages (cook time in seconds + power level), drives the
//               downstream timer's min/sec/start/stop/pause inputs and the
//               magnetron power level stage by stage, and inserts a fixed
//               stand time between consecutive stages.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   start/stop/pause    : single-cycle button pulses
//   porta               : door level, 1 = closed
//   wr_en/wr_idx/wr_sec/wr_pot : stage table write port (IDLE only)
//   num_stages          : active stage count, sampled at program start
//   timer_done          : timer expiry pulse
//   t_min/t_sec         : time presented to the timer (held per stage)
//   t_start/t_stop/t_pause : timer control pulses
//   pot_out             : active power level, 0 = magnetron off
//   stage_idx           : current stage index
//   busy                : high whenever the sequencer is not IDLE
//   prog_done           : program completed pulse
// ============================================================================
module ctrl_microondas_seq #(
    parameter int NSTAGES    = 4,
    parameter int IDXW       = 2,
    parameter int GAP_CYCLES = 100
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            stop,
    input  logic            pause,
    input  logic            porta,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_idx,
    input  logic [12:0]     wr_sec,
    input  logic [1:0]      wr_pot,
    input  logic [IDXW:0]   num_stages,
    input  logic            timer_done,
    output logic [6:0]      t_min,
    output logic [6:0]      t_sec,
    output logic            t_start,
    output logic            t_stop,
    output logic            t_pause,
    output logic [1:0]      pot_out,
    output logic [IDXW-1:0] stage_idx,
    output logic            busy,
    output logic            prog_done
);

    localparam int             GCW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_CYCLES - 1);
    localparam logic [12:0]    MAX_SEC  = 13'd5999;
    localparam logic [IDXW:0]  NST_MAX  = (IDXW+1)'(NSTAGES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_RUN    = 3'd3,
        S_PAUSED = 3'd4,
        S_GAP    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] stage_idx_q, stage_idx_d;
    logic [IDXW:0]   nst_q, nst_d;
    logic [GCW-1:0]  gap_q, gap_d;
    logic [12:0]     time_q [NSTAGES];
    logic [1:0]      pot_tab_q [NSTAGES];
    logic [6:0]      t_min_q, t_min_d, t_sec_q, t_sec_d;
    logic            t_start_q, t_stop_q, t_stop_d, t_pause_q, t_pause_d;
    logic [1:0]      pot_q, pot_d;
    logic            busy_q, prog_done_q;

    logic [12:0]     w_wr_sec;
    logic [IDXW:0]   w_nst_eff;
    logic            w_first_ok, w_next_ok;
    logic [IDXW-1:0] w_first_idx, w_next_idx;
    logic [12:0]     w_ld_time;

    assign w_wr_sec  = (wr_sec > MAX_SEC) ? MAX_SEC : wr_sec;
    assign w_nst_eff = (num_stages == '0 || num_stages > NST_MAX) ? NST_MAX : num_stages;

    // Lowest qualifying index wins: scan downwards so the last hit is the lowest.
    // "first" searches from 0 with the live num_stages (used at start);
    // "next" searches above the current stage with the sampled count.
    always_comb begin
        w_first_ok  = 1'b0;
        w_first_idx = '0;
        w_next_ok   = 1'b0;
        w_next_idx  = '0;
        for (int i = NSTAGES - 1; i >= 0; i--) begin
            if (i < int'(w_nst_eff) && time_q[i] != 13'd0) begin
                w_first_ok  = 1'b1;
                w_first_idx = IDXW'(i);
            end
            if (i > int'(stage_idx_q) && i < int'(nst_q) && time_q[i] != 13'd0) begin
                w_next_ok  = 1'b1;
                w_next_idx = IDXW'(i);
            end
        end
    end

    // Stage table: writable only while idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NSTAGES; i++) begin
                time_q[i]    <= '0;
                pot_tab_q[i] <= 2'd1;
            end
        end else if (wr_en && state_q == S_IDLE && int'(wr_idx) < NSTAGES) begin
            time_q[wr_idx]    <= w_wr_sec;
            pot_tab_q[wr_idx] <= (wr_pot == 2'd0) ? 2'd1 : wr_pot;
        end
    end

    // Next-state logic. Pause transitions are blocked for one cycle after a
    // t_pause pulse so that pulse can never stretch to two cycles.
    always_comb begin
        state_d     = state_q;
        stage_idx_d = stage_idx_q;
        nst_d       = nst_q;
        gap_d       = gap_q;
        t_stop_d    = 1'b0;
        t_pause_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && porta) begin
                    nst_d = w_nst_eff;
                    if (w_first_ok) begin
                        stage_idx_d = w_first_idx;
                        state_d     = S_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD:  state_d = S_START;
            S_START: state_d = S_RUN;
            S_RUN: begin
                if (stop) begin
                    t_stop_d = 1'b1;
                    state_d  = S_IDLE;
                end else if (timer_done) begin
                    gap_d   = '0;
                    state_d = w_next_ok ? S_GAP : S_DONE;
                end else if ((pause || !porta) && !t_pause_q) begin
                    t_pause_d = 1'b1;
                    state_d   = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (stop) begin
                    t_stop_d = 1'b1;
                    state_d  = S_IDLE;
                end else if ((start || pause) && porta && !t_pause_q) begin
                    t_pause_d = 1'b1;
                    state_d   = S_RUN;
                end
            end
            S_GAP: begin
                // Timer is already idle here, so stop needs no t_stop pulse.
                if (stop) begin
                    state_d = S_IDLE;
                end else if (porta) begin
                    if (gap_q == GAP_LAST) begin
                        stage_idx_d = w_next_idx;
                        state_d     = S_LOAD;
                    end else begin
                        gap_d = gap_q + GCW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE || state_d == S_DONE) begin
            stage_idx_d = '0;
            gap_d       = '0;
        end
    end

    // Outputs are registered from the next state so they change with it.
    assign w_ld_time = time_q[stage_idx_d];

    always_comb begin
        t_min_d = t_min_q;
        t_sec_d = t_sec_q;
        if (state_d == S_LOAD) begin
            t_min_d = 7'(w_ld_time / 13'd60);
            t_sec_d = 7'(w_ld_time % 13'd60);
        end else if (state_d == S_IDLE) begin
            t_min_d = '0;
            t_sec_d = '0;
        end
        pot_d = (state_d == S_RUN) ? pot_tab_q[stage_idx_d] : 2'd0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            stage_idx_q <= '0;
            nst_q       <= '0;
            gap_q       <= '0;
            t_min_q     <= '0;
            t_sec_q     <= '0;
            t_start_q   <= 1'b0;
            t_stop_q    <= 1'b0;
            t_pause_q   <= 1'b0;
            pot_q       <= '0;
            busy_q      <= 1'b0;
            prog_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_idx_q <= stage_idx_d;
            nst_q       <= nst_d;
            gap_q       <= gap_d;
            t_min_q     <= t_min_d;
            t_sec_q     <= t_sec_d;
            t_start_q   <= (state_d == S_START);
            t_stop_q    <= t_stop_d;
            t_pause_q   <= t_pause_d;
            pot_q       <= pot_d;
            busy_q      <= (state_d != S_IDLE);
            prog_done_q <= (state_d == S_DONE);
        end
    end

    assign t_min     = t_min_q;
    assign t_sec     = t_sec_q;
    assign t_start   = t_start_q;
    assign t_stop    = t_stop_q;
    assign t_pause   = t_pause_q;
    assign pot_out   = pot_q;
    assign stage_idx = stage_idx_q;
    assign busy      = busy_q;
    assign prog_done = prog_done_q;

endmodule
`default_nettype wire

// File: doc/ctrl_microondas_seq.md
Name: ctrl_microondas_seq

Overview:
Multi-stage cooking program sequencer for the microwave controller. It holds a small table of stages, each with a cook time and a power level. It drives the existing timer's min/sec/start/stop/pause inputs and the power output stage by stage, and inserts a fixed stand time between stages. Button inputs are single-cycle pulses produced upstream by edge_detector instances.

Parameters:
NSTAGES, 4, number of program stages in the table
IDXW, 2, stage index width (ceil(log2(NSTAGES)))
GAP_CYCLES, 100, stand-time length between stages, in clock cycles (>=1)

Ports:
clock  in  1  system clock; all state updates on its rising edge
reset  in  1  asynchronous, active-low reset (reset=0 resets immediately)
start  in  1  start/resume pulse
stop  in  1  stop pulse
pause  in  1  pause/resume toggle pulse
porta  in  1  door closed=1, open=0 (level)
wr_en  in  1  stage table write strobe
wr_idx  in  IDXW  stage index to write
wr_sec  in  13  stage time in seconds
wr_pot  in  2  stage power level
num_stages  in  IDXW+1  number of active stages, 1..NSTAGES
timer_done  in  1  timer finished pulse
t_min  out  7  minutes presented to timer
t_sec  out  7  seconds presented to timer
t_start  out  1  timer start pulse
t_stop  out  1  timer stop pulse
t_pause  out  1  timer pause-toggle pulse
pot_out  out  2  active power level; 0 = magnetron off
stage_idx  out  IDXW  current stage index
busy  out  1  high in every state except IDLE
prog_done  out  1  program completed pulse

Behaviour:
- Reset: state IDLE. All outputs 0. Table times = 0, table powers = 1. Gap counter = 0.
- Table writes:
  - Accepted only in IDLE; ignored in all other states.
  - wr_sec > 5999 is clamped to 5999.
  - wr_pot of 0 is stored as 1.
  - num_stages is sampled at start; a value of 0 or above NSTAGES is treated as NSTAGES.
- States: IDLE, LOAD, START, RUN, PAUSED, GAP, DONE.
- IDLE:
  - start with porta=1: stage_idx = first index < num_stages with nonzero time, then go to LOAD.
  - If no such index exists, go to DONE instead.
  - start with porta=0 is ignored.
- Stage skipping: "next stage" always means the next index with nonzero time below num_stages. Zero-time stages are skipped without entering GAP.
- LOAD:
  - t_min = time/60 and t_sec = time%60.
  - Both are registered and held stable through RUN/PAUSED until the next LOAD or IDLE (then cleared to 0).
  - Goes to START after 1 cycle.
- START: t_start=1 for exactly 1 cycle, then RUN. Latency from start pulse to t_start is 2 cycles.
- RUN:
  - pot_out = stage power.
  - Priority order: stop > timer_done > (pause or porta=0).
  - stop: t_stop pulse (1 cycle), go to IDLE.
  - timer_done: if a next stage exists, go to GAP; else go to DONE.
  - pause or porta=0: t_pause pulse, go to PAUSED.
  - start in RUN is ignored.
- PAUSED:
  - pot_out = 0.
  - stop: t_stop pulse, go to IDLE.
  - (start or pause) with porta=1: t_pause pulse, return to RUN.
  - Resume while porta=0 is ignored.
- GAP:
  - pot_out = 0.
  - Counter runs GAP_CYCLES cycles, then advances stage_idx to the next stage and goes to LOAD.
  - porta=0 freezes the counter.
  - stop: go to IDLE with no t_stop (timer already idle).
  - pause and start are ignored.
- DONE: prog_done=1 for 1 cycle, then IDLE; stage_idx is cleared to 0.
- busy is registered alongside the state.
- Pulse outputs are never asserted for more than 1 consecutive cycle.
- Reset asserted mid-program forces all outputs to 0 immediately, with no t_stop pulse.

Test Plan:
1. Write stage0=90s pot3, stage1=5s pot1, num_stages=2, start -> t_min=1, t_sec=30 from LOAD; t_start 2 cycles after start; pot_out=3; after timer_done, pot_out=0 for 100 cycles; t_min=0, t_sec=5, t_start; pot_out=1; second timer_done -> prog_done pulse, busy=0.
2. RUN stage0, drop porta -> t_pause pulse, PAUSED, pot_out=0. start while porta=0 -> no change. porta=1 then pause -> t_pause pulse, RUN, pot_out restored.
3. timer_done and stop in the same RUN cycle -> t_stop pulse, IDLE, no GAP, no prog_done.
4. Stage table 0s, 0s, 20s, num_stages=3, start -> stage_idx=2 loaded directly with t_sec=20. All stages 0 -> prog_done 1 cycle after start, t_start never asserted.
5. wr_sec=7000 in IDLE -> runs as t_min=99, t_sec=59. wr_en during RUN -> table unchanged on the next run.
6. reset=0 asserted in GAP -> immediate IDLE, all outputs 0. After release, start runs stage0 with the table reset to 0 (prog_done path).
